// File: rtl/efuse_pkg.sv
// Shared definitions for the efuse access arbiter.
// FSM encoding, requester indices and controller modes.
package efuse_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_ARB   = 3'd1;
  localparam state_t S_START = 3'd2;
  localparam state_t S_WBUSY = 3'd3;
  localparam state_t S_WDONE = 3'd4;
  localparam state_t S_RESP  = 3'd5;

  localparam int REQ_PMU = 0;
  localparam int REQ_CPU = 1;
  localparam int REQ_DFT = 2;

  localparam logic [1:0] MODE_READ = 2'd0;
  localparam logic [1:0] MODE_PROG = 2'd1;

  localparam int BUSY_LIM = 4;

endpackage

// File: rtl/efuse_rr_arb.sv
// Two-way round-robin picker for the CPU/DFT requesters.
// Bit 0 is CPU, bit 1 is DFT; the pointer names who is preferred.
module efuse_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;
  logic ptr_d;

  // Grant the preferred requester, else the other one
  always_comb begin
    gnt_o = 2'b00;
    if (ptr_q == 1'b0) begin
      if (req_i[0])      gnt_o = 2'b01;
      else if (req_i[1]) gnt_o = 2'b10;
    end else begin
      if (req_i[1])      gnt_o = 2'b10;
      else if (req_i[0]) gnt_o = 2'b01;
    end
  end

  // Move preference past the winner when a grant is taken
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      unique case (1'b1)
        gnt_o[0]: ptr_d = 1'b1;
        gnt_o[1]: ptr_d = 1'b0;
        default:  ptr_d = ptr_q;
      endcase
    end
  end

  // Pointer register, CPU preferred out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/efuse_arb.sv
// Efuse access arbiter: PMU, CPU and DFT share one controller.
// PMU has fixed priority; CPU/DFT alternate round-robin.
module efuse_arb
  import efuse_pkg::*;
#(
  parameter  int NW      = 64,
  parameter  int NR      = 64,
  parameter  int TMO_CYC = 1023,
  localparam int SELW    = $clog2(256 / NW),
  localparam int RSELW   = $clog2(256 / NR)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         req_i,
  input  logic [2:0]         req_wr_i,
  input  logic [3*RSELW-1:0] req_rsel_i,
  input  logic [3*SELW-1:0]  req_wsel_i,
  input  logic [3*NW-1:0]    req_wdata_i,
  output logic [2:0]         gnt_o,
  output logic [2:0]         done_o,
  output logic [2:0]         err_o,
  output logic [NR-1:0]      rdata_o,
  output logic               ctrl_start_o,
  output logic [1:0]         ctrl_mode_o,
  output logic [RSELW-1:0]   ctrl_read_sel_o,
  output logic [SELW-1:0]    ctrl_write_sel_o,
  output logic [NW-1:0]      ctrl_wdata_o,
  input  logic               ctrl_busy_i,
  input  logic               ctrl_read_done_i,
  input  logic               ctrl_write_done_i,
  input  logic [NR-1:0]      ctrl_rdata_i,
  output logic               arb_busy_o
);

  localparam int CW = $clog2(TMO_CYC + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [2:0]       gnt_q, gnt_d;
  logic             tmo_q, tmo_d;
  logic [1:0]       mode_q, mode_d;
  logic [RSELW-1:0] rsel_q, rsel_d;
  logic [SELW-1:0]  wsel_q, wsel_d;
  logic [NW-1:0]    wdata_q, wdata_d;
  logic [NR-1:0]    rdata_q, rdata_d;

  logic [1:0]       rr_gnt;
  logic             rr_adv;
  logic [2:0]       win;
  logic             win_wr;
  logic [RSELW-1:0] win_rsel;
  logic [SELW-1:0]  win_wsel;
  logic [NW-1:0]    win_wdata;
  logic             op_done;

  assign rr_adv = (state_q == S_ARB) && !req_i[REQ_PMU]
                  && (req_i[REQ_CPU] || req_i[REQ_DFT]);

  efuse_rr_arb u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_i[REQ_DFT:REQ_CPU]),
    .adv_i (rr_adv),
    .gnt_o (rr_gnt)
  );

  assign win = req_i[REQ_PMU] ? 3'b001 : {rr_gnt, 1'b0};
  assign cnt_inc = cnt_q + CW'(1);
  assign op_done = (mode_q == MODE_PROG) ? ctrl_write_done_i
                                         : ctrl_read_done_i;

  // Pull the winning requester's operation fields
  always_comb begin
    win_wr    = 1'b0;
    win_rsel  = '0;
    win_wsel  = '0;
    win_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      if (win[i]) begin
        win_wr    = req_wr_i[i];
        win_rsel  = req_rsel_i[i*RSELW +: RSELW];
        win_wsel  = req_wsel_i[i*SELW +: SELW];
        win_wdata = req_wdata_i[i*NW +: NW];
      end
    end
  end

  // Sequencer: arbitrate, kick controller, wait, respond
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    tmo_d   = tmo_q;
    mode_d  = mode_q;
    rsel_d  = rsel_q;
    wsel_d  = wsel_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req_i) state_d = S_ARB;
      end
      S_ARB: begin
        if (|win) begin
          state_d = S_START;
          gnt_d   = win;
          tmo_d   = 1'b0;
          mode_d  = win_wr ? MODE_PROG : MODE_READ;
          rsel_d  = win_rsel;
          wsel_d  = win_wsel;
          wdata_d = win_wdata;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        state_d = S_WBUSY;
        cnt_d   = '0;
      end
      S_WBUSY: begin
        if (ctrl_busy_i) begin
          state_d = S_WDONE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(BUSY_LIM - 1)) begin
          state_d = S_RESP;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WDONE: begin
        if (op_done) begin
          state_d = S_RESP;
          if (mode_q == MODE_READ) rdata_d = ctrl_rdata_i;
        end else if (cnt_inc == CW'(TMO_CYC)) begin
          state_d = S_RESP;
          tmo_d   = 1'b1;
          cnt_d   = cnt_inc;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      tmo_q   <= 1'b0;
      mode_q  <= MODE_READ;
      rsel_q  <= '0;
      wsel_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      tmo_q   <= tmo_d;
      mode_q  <= mode_d;
      rsel_q  <= rsel_d;
      wsel_q  <= wsel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign gnt_o            = gnt_q;
  assign done_o           = (state_q == S_RESP) ? gnt_q : 3'b000;
  assign err_o            = (state_q == S_RESP && tmo_q) ? gnt_q : 3'b000;
  assign rdata_o          = rdata_q;
  assign ctrl_start_o     = (state_q == S_START);
  assign ctrl_mode_o      = mode_q;
  assign ctrl_read_sel_o  = rsel_q;
  assign ctrl_write_sel_o = wsel_q;
  assign ctrl_wdata_o     = wdata_q;
  assign arb_busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_efuse_arb.sv
// Self-checking bench for efuse_arb.
// Directed table, hand sequences, randomized traffic vs. a model.
module tb_efuse_arb;

  localparam int NW    = 64;
  localparam int NR    = 64;
  localparam int TMO   = 15;
  localparam int SELW  = 2;
  localparam int RSELW = 2;

  logic               clk;
  logic               rst_n;
  logic [2:0]         req;
  logic [2:0]         wr;
  logic [3*RSELW-1:0] rsel;
  logic [3*SELW-1:0]  wsel;
  logic [3*NW-1:0]    wdata;
  logic [2:0]         gnt_o, done_o, err_o;
  logic [NR-1:0]      rdata_o;
  logic               ctrl_start_o;
  logic [1:0]         ctrl_mode_o;
  logic [RSELW-1:0]   ctrl_read_sel_o;
  logic [SELW-1:0]    ctrl_write_sel_o;
  logic [NW-1:0]      ctrl_wdata_o;
  logic               busy, rdone, wdone;
  logic [NR-1:0]      crdata;
  logic               arb_busy_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int ctl_cfg = 0;
  bit ctl_fix = 0;
  logic [63:0] ctl_fix_val = '0;
  logic [63:0] ctl_rdata_v = '0;

  efuse_arb #(.NW(NW), .NR(NR), .TMO_CYC(TMO)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_i             (req),
    .req_wr_i          (wr),
    .req_rsel_i        (rsel),
    .req_wsel_i        (wsel),
    .req_wdata_i       (wdata),
    .gnt_o             (gnt_o),
    .done_o            (done_o),
    .err_o             (err_o),
    .rdata_o           (rdata_o),
    .ctrl_start_o      (ctrl_start_o),
    .ctrl_mode_o       (ctrl_mode_o),
    .ctrl_read_sel_o   (ctrl_read_sel_o),
    .ctrl_write_sel_o  (ctrl_write_sel_o),
    .ctrl_wdata_o      (ctrl_wdata_o),
    .ctrl_busy_i       (busy),
    .ctrl_read_done_i  (rdone),
    .ctrl_write_done_i (wdone),
    .ctrl_rdata_i      (crdata),
    .arb_busy_o        (arb_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: 0 normal, 1 never busy, 2 busy but never done
  initial begin
    int cc;
    int lat;
    busy = 0; rdone = 0; wdone = 0; crdata = '0; cc = -1; lat = 1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0; rdone = 0; wdone = 0; cc = -1;
      end else begin
        rdone = 0; wdone = 0;
        if (ctrl_start_o) begin
          cc = 0;
          lat = $urandom_range(1, 3);
          ctl_rdata_v = ctl_fix ? ctl_fix_val : {$urandom, $urandom};
          crdata = ctl_rdata_v;
          busy = (ctl_cfg != 1);
        end else if (cc >= 0) begin
          cc++;
          if (ctl_cfg == 0 && cc == 2) begin
            if (ctrl_mode_o == 2'd1) rdone = 1;
            else wdone = 1;
          end
          if (ctl_cfg == 0 && cc == lat + 2) begin
            busy = 0;
            if (ctrl_mode_o == 2'd1) wdone = 1;
            else rdone = 1;
            cc = -1;
          end
          if (cc == 40) begin
            busy = 0; cc = -1;
          end
        end
      end
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic setf(int i, bit w, logic [1:0] rs, logic [1:0] ws,
                      logic [63:0] wd);
    wr[i] = w;
    rsel[i*RSELW +: RSELW] = rs;
    wsel[i*SELW +: SELW] = ws;
    wdata[i*NW +: NW] = wd;
  endtask

  task automatic wait_start(output int t);
    bit found;
    found = 0;
    t = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ctrl_start_o) begin
        found = 1;
        t = cyc;
        break;
      end
    end
    chk("start_seen", 64'(found), 64'd1);
  endtask

  task automatic wait_done(output int t);
    bit found;
    found = 0;
    t = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_o != 3'b000) begin
        found = 1;
        t = cyc;
        break;
      end
    end
    chk("done_seen", 64'(found), 64'd1);
  endtask

  function automatic int oh2i(logic [2:0] v);
    return v[0] ? 0 : (v[1] ? 1 : 2);
  endfunction

  typedef struct {
    logic [2:0] req;
    logic [2:0] wr;
    logic [2:0] gnt;
    logic [1:0] mode;
  } vec_t;

  vec_t tbl[11];

  bit          pend[3];
  bit          w_m[3];
  logic [1:0]  rs_m[3];
  logic [1:0]  ws_m[3];
  logic [63:0] wd_m[3];

  initial begin
    int ts, td, t0, w, pref, exp_w, dec_cyc;
    bit busy_m, started, clr, exp_st, seen;
    logic [2:0] exp_g;
    logic [63:0] exp_rd;
    logic [2:0] ord[4];

    tbl[0]  = '{3'b001, 3'b000, 3'b001, 2'd0};
    tbl[1]  = '{3'b110, 3'b010, 3'b010, 2'd1};
    tbl[2]  = '{3'b110, 3'b000, 3'b100, 2'd0};
    tbl[3]  = '{3'b111, 3'b111, 3'b001, 2'd1};
    tbl[4]  = '{3'b110, 3'b100, 3'b010, 2'd0};
    tbl[5]  = '{3'b010, 3'b010, 3'b010, 2'd1};
    tbl[6]  = '{3'b110, 3'b110, 3'b100, 2'd1};
    tbl[7]  = '{3'b100, 3'b000, 3'b100, 2'd0};
    tbl[8]  = '{3'b110, 3'b000, 3'b010, 2'd0};
    tbl[9]  = '{3'b101, 3'b001, 3'b001, 2'd1};
    tbl[10] = '{3'b110, 3'b110, 3'b100, 2'd1};

    rst_n = 0; req = 0; wr = 0; rsel = 0; wsel = 0; wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 64'(gnt_o), 0);
    chk("rst_done", 64'(done_o), 0);
    chk("rst_start", 64'(ctrl_start_o), 0);
    chk("rst_busy", 64'(arb_busy_o), 0);
    chk("rst_rdata", rdata_o, 0);
    rst_n = 1;
    @(negedge clk);

    // All three held: PMU, then CPU, then DFT
    for (int i = 0; i < 3; i++) setf(i, 0, 2'(i), 2'(i), {$urandom, $urandom});
    req = 3'b111;
    ord[0] = 3'b001; ord[1] = 3'b010; ord[2] = 3'b100;
    for (int k = 0; k < 3; k++) begin
      wait_start(ts);
      chk("all3_gnt", 64'(gnt_o), 64'(ord[k]));
      wait_done(td);
      chk("all3_done", 64'(done_o), 64'(ord[k]));
      req = req & ~done_o;
    end
    // CPU+DFT repeating alternate
    req = 3'b110;
    for (int k = 0; k < 4; k++) begin
      exp_g = k[0] ? 3'b100 : 3'b010;
      wait_start(ts);
      chk("rr_gnt", 64'(gnt_o), 64'(exp_g));
      wait_done(td);
      chk("rr_done", 64'(done_o), 64'(exp_g));
      req = (k == 3) ? 3'b000 : 3'b110;
    end
    @(negedge clk);

    // Table of single operations
    for (int v = 0; v < 11; v++) begin
      for (int i = 0; i < 3; i++)
        setf(i, tbl[v].wr[i], 2'($urandom), 2'($urandom), {$urandom, $urandom});
      req = tbl[v].req;
      w = oh2i(tbl[v].gnt);
      wait_start(ts);
      chk("tbl_gnt", 64'(gnt_o), 64'(tbl[v].gnt));
      chk("tbl_mode", 64'(ctrl_mode_o), 64'(tbl[v].mode));
      chk("tbl_rsel", 64'(ctrl_read_sel_o), 64'(rsel[w*RSELW +: RSELW]));
      chk("tbl_wsel", 64'(ctrl_write_sel_o), 64'(wsel[w*SELW +: SELW]));
      chk("tbl_wdata", ctrl_wdata_o, wdata[w*NW +: NW]);
      wait_done(td);
      chk("tbl_done", 64'(done_o), 64'(tbl[v].gnt));
      chk("tbl_err", 64'(err_o), 0);
      req = 0;
      @(negedge clk);
    end

    // PMU read, latency and data capture
    ctl_fix = 1; ctl_fix_val = 64'h123456789ABCDEF0;
    setf(0, 0, 2'd2, 2'd0, 64'd0);
    req = 3'b001;
    t0 = cyc;
    wait_start(ts);
    chk("pmu_latency", 64'(ts - t0), 64'd2);
    chk("pmu_rsel", 64'(ctrl_read_sel_o), 64'd2);
    chk("pmu_mode", 64'(ctrl_mode_o), 64'd0);
    wait_done(td);
    chk("pmu_done", 64'(done_o), 64'b001);
    chk("pmu_rdata", rdata_o, 64'h123456789ABCDEF0);
    req = 0;
    ctl_fix = 0;
    @(negedge clk);
    chk("pmu_idle", 64'(arb_busy_o), 0);

    // CPU program leaves rdata alone
    setf(1, 1, 2'd0, 2'd1, 64'hf0f1f2f3f4f5f6f7);
    req = 3'b010;
    wait_start(ts);
    chk("cpu_mode", 64'(ctrl_mode_o), 64'd1);
    chk("cpu_wsel", 64'(ctrl_write_sel_o), 64'd1);
    chk("cpu_wdata", ctrl_wdata_o, 64'hf0f1f2f3f4f5f6f7);
    wait_done(td);
    chk("cpu_done", 64'(done_o), 64'b010);
    chk("cpu_rdata", rdata_o, 64'h123456789ABCDEF0);
    req = 0;
    @(negedge clk);

    // Controller never goes busy
    ctl_cfg = 1;
    setf(1, 0, 2'd1, 2'd0, 64'd0);
    req = 3'b010;
    wait_start(ts);
    wait_done(td);
    chk("nobusy_delay", 64'(td - ts), 64'd5);
    chk("nobusy_err", 64'(err_o), 64'b010);
    chk("nobusy_rdata", rdata_o, 64'h123456789ABCDEF0);
    req = 0;
    @(negedge clk);
    chk("nobusy_idle", 64'(arb_busy_o), 0);

    // Busy but no done: wait-done timeout
    ctl_cfg = 2;
    setf(0, 0, 2'd3, 2'd0, 64'd0);
    req = 3'b001;
    wait_start(ts);
    wait_done(td);
    chk("tmo_delay", 64'(td - (ts + 2)), 64'(TMO));
    chk("tmo_err", 64'(err_o), 64'b001);
    req = 0;
    @(negedge clk);

    // Reset in the middle of WAIT_DONE
    setf(2, 1, 2'd0, 2'd3, 64'hdeadbeefcafef00d);
    req = 3'b100;
    wait_start(ts);
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    chk("mrst_gnt", 64'(gnt_o), 0);
    chk("mrst_done_err", 64'({done_o, err_o}), 0);
    chk("mrst_ctrl", 64'({ctrl_start_o, ctrl_mode_o, ctrl_read_sel_o,
                          ctrl_write_sel_o}), 0);
    chk("mrst_wdata", ctrl_wdata_o, 0);
    chk("mrst_rdata", rdata_o, 0);
    chk("mrst_busy", 64'(arb_busy_o), 0);
    @(negedge clk);
    rst_n = 1; req = 0; ctl_cfg = 0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done_o != 0) seen = 1;
    end
    chk("mrst_no_done", 64'(seen), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3; i++) pend[i] = 0;
    pref = 1; busy_m = 0; started = 0; exp_w = 0; dec_cyc = 0;
    exp_rd = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      clr = 0;
      exp_st = busy_m && (cyc == dec_cyc + 2);
      if (ctrl_start_o || exp_st) begin
        chk("rnd_start", 64'(ctrl_start_o), 64'(exp_st));
        if (ctrl_start_o && exp_st) begin
          started = 1;
          chk("rnd_gnt", 64'(gnt_o), 64'(1 << exp_w));
          chk("rnd_mode", 64'(ctrl_mode_o), 64'(w_m[exp_w]));
          chk("rnd_rsel", 64'(ctrl_read_sel_o), 64'(rs_m[exp_w]));
          chk("rnd_wsel", 64'(ctrl_write_sel_o), 64'(ws_m[exp_w]));
          chk("rnd_wdata", ctrl_wdata_o, wd_m[exp_w]);
        end
      end
      if (done_o != 0 || (busy_m && cyc - dec_cyc > 60)) begin
        if (!busy_m) begin
          chk("rnd_spurious_done", 64'(done_o), 0);
        end else begin
          if (!w_m[exp_w]) exp_rd = ctl_rdata_v;
          chk("rnd_done", 64'(done_o), 64'(1 << exp_w));
          chk("rnd_err", 64'(err_o), 0);
          chk("rnd_rdata", rdata_o, exp_rd);
          pend[exp_w] = 0;
          req[exp_w] = 0;
          clr = 1;
        end
      end
      if (!(busy_m && cyc == dec_cyc + 1)) begin
        for (int i = 0; i < 3; i++) begin
          if (!pend[i] && $urandom_range(0, 7) == 0) begin
            w_m[i] = 1'($urandom);
            rs_m[i] = 2'($urandom);
            ws_m[i] = 2'($urandom);
            wd_m[i] = {$urandom, $urandom};
            setf(i, w_m[i], rs_m[i], ws_m[i], wd_m[i]);
            pend[i] = 1;
            req[i] = 1;
          end
        end
      end
      if (busy_m && started && !clr && $urandom_range(0, 15) == 0)
        req[exp_w] = 0;
      if (!busy_m && (pend[0] || pend[1] || pend[2])) begin
        if (pend[0]) exp_w = 0;
        else if (pend[1] && pend[2]) exp_w = pref;
        else exp_w = pend[1] ? 1 : 2;
        if (exp_w != 0) pref = (exp_w == 1) ? 2 : 1;
        dec_cyc = cyc;
        busy_m = 1;
        started = 0;
      end
      if (clr) busy_m = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
